// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the core/register file and the
// iterative multiply/divide unit.
//   Request  (core -> unit): start_i, op_i, op_a_i, op_b_i, rd_adr_i, flush_i
//   Response (unit -> core): busy_o, done_o, result_o, we_o, wd_adr_o, wd_o
// master modport is the core side, slave modport is the unit side.
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [4:0]      rd_adr_i;
    logic            flush_i;

    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic            we_o;
    logic [4:0]      wd_adr_o;
    logic [XLEN-1:0] wd_o;

    modport master (
        output start_i, op_i, op_a_i, op_b_i, rd_adr_i, flush_i,
        input  busy_o, done_o, result_o, we_o, wd_adr_o, wd_o
    );

    modport slave (
        input  start_i, op_i, op_a_i, op_b_i, rd_adr_i, flush_i,
        output busy_o, done_o, result_o, we_o, wd_adr_o, wd_o
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit placed after the register file.
// Operands arrive from the RF read ports, the result is written back through the
// RF write port with one we_o pulse per completed operation (suppressed for x0).
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : mdu_iter_if.slave (start/op/operands/rd/flush in, busy/done/result/RF write out)
// Multiplies use shift-add, divides use restoring division, both on operand
// magnitudes with a sign fix-up folded into the final cycle. Divide-by-zero and
// signed overflow bypass the iteration and finish one cycle after the start.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic       clk_i,
    input logic       rst_i,
    mdu_iter_if.slave bus
);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   pend_q, pend_d;     // result of the operation in flight
    logic [XLEN-1:0]   res_q, res_d;       // last committed result
    logic [4:0]        wd_adr_q, wd_adr_d; // last committed write address

    // Datapath helpers
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;
    logic              in_sa;
    logic              in_sb;
    logic [XLEN-1:0]   in_a_mag;
    logic [XLEN-1:0]   in_b_mag;
    logic              commit;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        res_d    = res_q;
        wd_adr_d = wd_adr_q;

        // Shift-add: low half of acc holds the remaining multiplier bits,
        // high half accumulates the partial product.
        mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_mag_q})
                            : {1'b0, acc_q[2*XLEN-1:XLEN]};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring division: high half is the partial remainder, low half the
        // dividend shifting out while quotient bits shift in. The borrow bit of
        // the trial subtraction decides whether the remainder is restored.
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_mag_q};
        div_rem   = div_trial[XLEN] ? acc_q[2*XLEN-2:XLEN-1] : div_trial[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], ~div_trial[XLEN]};

        step = op_q[2] ? div_next : mul_next;

        // Sign fix-up is applied to the value produced by the last iteration so
        // the result lands in DONE without an extra cycle. Unsigned ops never
        // set the neg flags, so the fix-up is a no-op for them.
        prod_fix = (a_neg_q ^ b_neg_q) ? (~step + 1'b1) : step;
        quo_fix  = (a_neg_q ^ b_neg_q) ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
        rem_fix  = a_neg_q ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:    final_res = prod_fix[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV:    final_res = quo_fix;
            OP_DIVU:   final_res = step[XLEN-1:0];
            OP_REM:    final_res = rem_fix;
            OP_REMU:   final_res = step[2*XLEN-1:XLEN];
            default:   final_res = '0;
        endcase

        // Operand signedness for the incoming request
        in_sa    = ((bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                    (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM)) && bus.op_a_i[XLEN-1];
        in_sb    = ((bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) ||
                    (bus.op_i == OP_REM)) && bus.op_b_i[XLEN-1];
        in_a_mag = in_sa ? (~bus.op_a_i + 1'b1) : bus.op_a_i;
        in_b_mag = in_sb ? (~bus.op_b_i + 1'b1) : bus.op_b_i;

        case (state_q)
            S_IDLE: begin
                if (!bus.flush_i && bus.start_i) begin
                    op_d    = bus.op_i;
                    rd_d    = bus.rd_adr_i;
                    a_mag_d = in_a_mag;
                    b_mag_d = in_b_mag;
                    a_neg_d = in_sa;
                    b_neg_d = in_sb;
                    cnt_d   = '0;
                    if (bus.op_i[2] && (bus.op_b_i == '0)) begin
                        // Divide by zero: quotient all ones, remainder = dividend
                        pend_d  = bus.op_i[1] ? bus.op_a_i : '1;
                        state_d = S_DONE;
                    end else if (bus.op_i[2] && !bus.op_i[0] &&
                                 (bus.op_a_i == INT_MIN) && (bus.op_b_i == '1)) begin
                        // Signed overflow: quotient INT_MIN, remainder 0
                        pend_d  = bus.op_i[1] ? '0 : INT_MIN;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, (bus.op_i[2] ? in_a_mag : in_b_mag)};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        pend_d  = final_res;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.flush_i) begin
                    res_d    = pend_q;
                    wd_adr_d = rd_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            res_q    <= '0;
            wd_adr_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            res_q    <= res_d;
            wd_adr_q <= wd_adr_d;
        end
    end

    // A flush arriving during DONE must cancel the write in that very cycle,
    // so the committed view is muxed from registers gated by flush_i.
    assign commit       = (state_q == S_DONE) && !bus.flush_i;
    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = commit;
    assign bus.we_o     = commit && (rd_q != 5'd0);
    assign bus.result_o = commit ? pend_q : res_q;
    assign bus.wd_o     = commit ? pend_q : res_q;
    assign bus.wd_adr_o = commit ? rd_q : wd_adr_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed-vector bench for mdu_iter. Stimulus pushes expected
// write-backs into a queue; a monitor pops and compares on every done_o.
module tb_mdu_iter;
    logic clk;
    logic rst;

    mdu_iter_if #(.XLEN(32)) bif ();

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compares every write-back against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (bif.done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h required=none", bif.result_o);
            end else begin
                e = exp_q.pop_front();
                chk("result_o", bif.result_o, e.res);
                chk("wd_o", bif.wd_o, e.res);
                chk("wd_adr_o", {27'd0, bif.wd_adr_o}, {27'd0, e.rd});
                chk("we_o", {31'd0, bif.we_o}, {31'd0, e.we});
                $display("txn rd=%0d result=%h we=%0b", bif.wd_adr_o, bif.result_o, bif.we_o);
            end
        end else if (bif.we_o) begin
            chk("we_without_done", {31'd0, bif.we_o}, 32'd0);
        end
        if (bif.we_o) writes++;
    end

    // abort_kind: 0 none, 1 flush at abort_at, 2 reset at abort_at.
    // For aborted ops exp_res is the result_o value that must remain visible.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                          input int exp_lat, input int pulse_at, input int abort_kind,
                          input int abort_at);
        int   lat;
        int   busy_cnt;
        int   w0;
        exp_t e;
        @(negedge clk);
        bif.op_i     = op;
        bif.op_a_i   = a;
        bif.op_b_i   = b;
        bif.rd_adr_i = rd;
        bif.start_i  = 1'b1;
        if (abort_kind == 0) begin
            e.res = exp_res;
            e.rd  = rd;
            e.we  = (rd != 5'd0);
            exp_q.push_back(e);
        end
        w0 = writes;
        @(negedge clk);
        bif.start_i = 1'b0;
        // Operands must have been latched; disturb the inputs
        bif.op_a_i  = ~a;
        bif.op_b_i  = b ^ 32'h5A5A_5A5A;
        lat      = 1;
        busy_cnt = 0;
        if (abort_kind == 0) begin
            while (!bif.done_o && lat < 60) begin
                busy_cnt += int'(bif.busy_o);
                bif.start_i = (lat == pulse_at);
                @(negedge clk);
                lat++;
            end
            bif.start_i = 1'b0;
            busy_cnt += int'(bif.busy_o);
            chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
            @(negedge clk);
            chk({name, "_idle_after"}, {31'd0, bif.busy_o}, 32'd0);
            chk({name, "_write_count"}, 32'(writes - w0), (rd != 5'd0) ? 32'd1 : 32'd0);
        end else begin
            while (lat < abort_at) begin
                @(negedge clk);
                lat++;
            end
            if (abort_kind == 1) begin
                bif.flush_i = 1'b1;
                chk({name, "_done_in_flush"}, {31'd0, bif.done_o}, 32'd0);
                chk({name, "_we_in_flush"}, {31'd0, bif.we_o}, 32'd0);
            end else begin
                rst = 1'b1;
            end
            @(negedge clk);
            bif.flush_i = 1'b0;
            rst         = 1'b0;
            chk({name, "_busy_after"}, {31'd0, bif.busy_o}, 32'd0);
            chk({name, "_done_after"}, {31'd0, bif.done_o}, 32'd0);
            chk({name, "_we_after"}, {31'd0, bif.we_o}, 32'd0);
            chk({name, "_result_after"}, bif.result_o, exp_res);
            chk({name, "_wd_after"}, bif.wd_o, exp_res);
            if (abort_kind == 2)
                chk({name, "_wd_adr_after"}, {27'd0, bif.wd_adr_o}, 32'd0);
            repeat (40) @(negedge clk);
            chk({name, "_no_write"}, 32'(writes - w0), 32'd0);
            chk({name, "_result_held"}, bif.result_o, exp_res);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bif.start_i  = 1'b0;
        bif.op_i     = 3'd0;
        bif.op_a_i   = 32'd0;
        bif.op_b_i   = 32'd0;
        bif.rd_adr_i = 5'd0;
        bif.flush_i  = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            chk("reset_busy", {31'd0, bif.busy_o}, 32'd0);
            chk("reset_done", {31'd0, bif.done_o}, 32'd0);
            chk("reset_we", {31'd0, bif.we_o}, 32'd0);
            chk("reset_result", bif.result_o, 32'd0);
            chk("reset_wd", bif.wd_o, 32'd0);
        end
        rst = 1'b0;

        //      name      op    a             b             rd     expected      lat pulse abort at
        run_op("mul",    3'd0, 32'd7,        32'd6,        5'd5,  32'd42,        33, 0, 0, 0);
        run_op("mulh",   3'd1, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF,  33, 0, 0, 0);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'd2,        5'd6,  32'h00000001,  33, 0, 0, 0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF,  33, 0, 0, 0);
        run_op("mul_neg",3'd0, 32'hFFFFFFFD, 32'd5,        5'd8,  32'hFFFFFFF1,  33, 0, 0, 0);
        run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD,  33, 0, 0, 0);
        run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF,  33, 0, 0, 0);
        run_op("divu",   3'd5, 32'd100,      32'd7,        5'd11, 32'd14,        33, 0, 0, 0);
        run_op("remu",   3'd7, 32'd100,      32'd7,        5'd12, 32'd2,         33, 0, 0, 0);
        run_op("div0",   3'd4, 32'd123,      32'd0,        5'd13, 32'hFFFFFFFF,  1,  0, 0, 0);
        run_op("rem0",   3'd6, 32'd123,      32'd0,        5'd14, 32'd123,       1,  0, 0, 0);
        run_op("divu0",  3'd5, 32'd123,      32'd0,        5'd15, 32'hFFFFFFFF,  1,  0, 0, 0);
        run_op("remu0",  3'd7, 32'd5,        32'd0,        5'd16, 32'd5,         1,  0, 0, 0);
        run_op("div_ovf",3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000,  1,  0, 0, 0);
        run_op("rem_ovf",3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,         1,  0, 0, 0);
        run_op("restart",3'd0, 32'd7,        32'd6,        5'd19, 32'd42,        33, 10, 0, 0);
        run_op("rd_x0",  3'd5, 32'd100,      32'd7,        5'd0,  32'd14,        33, 0, 0, 0);
        run_op("flush",  3'd0, 32'd3,        32'd3,        5'd4,  32'd14,        0,  0, 1, 15);
        run_op("reset",  3'd0, 32'd3,        32'd3,        5'd4,  32'd0,         0,  0, 2, 20);
        run_op("fresh",  3'd0, 32'd3,        32'd3,        5'd4,  32'd9,         33, 0, 0, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
